// File: rtl/serial_addsub_fsm.sv
// rtl/serial_addsub_fsm.sv - bit-serial add/subtract unit, LSB first, with valid/ready operand and result handshakes
// One full-add/full-subtract cell is reused for WIDTH clocks; carry/borrow lives in cb_reg between bits.
module serial_addsub_fsm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cbin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cbout,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sub_r;
    logic             cb_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_r;
    logic             cbout_r;

    logic             accept;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;
    logic             prop;
    logic             sum_bit;
    logic             cb_next;

    assign accept   = (state == S_IDLE) && in_valid;
    assign last_bit = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

    // Single full-add / full-subtract cell; subtraction differs only in the carry/borrow term.
    always_comb begin
        a_bit   = a_sh[0];
        b_bit   = b_sh[0];
        prop    = a_bit ^ b_bit;
        sum_bit = prop ^ cb_reg;
        if (sub_r) begin
            cb_next = (~a_bit & b_bit) | (cb_reg & ~prop);
        end else begin
            cb_next = (a_bit & b_bit) | (cb_reg & prop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sub_r    <= 1'b0;
            cb_reg   <= 1'b0;
            cnt      <= '0;
            result_r <= '0;
            cbout_r  <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sub_r  <= sub;
            cb_reg <= cbin;
            cnt    <= '0;
        end else if (state == S_RUN) begin
            a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
            cb_reg   <= cb_next;
            cnt      <= cnt + CW'(1);
            result_r <= {sum_bit, result_r[WIDTH-1:1]};
            if (last_bit) begin
                cbout_r <= cb_next;
            end
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN);
    assign result    = result_r;
    assign cbout     = cbout_r;

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// tb/tb_serial_addsub_fsm.sv - self-checking bench for serial_addsub_fsm with an expected-result scoreboard
module tb_serial_addsub_fsm;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cbin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cbout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [W:0] sb[$];

    serial_addsub_fsm #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cbin      (cbin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cbout     (cbout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Integer arithmetic reference: {cbout, result}
    function automatic logic [W:0] model(input int av, input int bv, input int sv, input int cv);
        int r;
        logic cb;
        if (sv != 0) begin
            r  = av - bv - cv;
            cb = (av < bv + cv);
            r  = (r + (1 << W)) % (1 << W);
        end else begin
            r  = av + bv + cv;
            cb = (r >= (1 << W));
            r  = r % (1 << W);
        end
        return {cb, r[W-1:0]};
    endfunction

    // Combinational ripple-carry adder reference
    function automatic logic [W:0] ripple(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] r;
        logic c;
        c = cv;
        for (int i = 0; i < W; i++) begin
            r[i] = av[i] ^ bv[i] ^ c;
            c    = (av[i] & bv[i]) | (c & (av[i] ^ bv[i]));
        end
        r[W] = c;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int av, input int bv, input int sv, input int cv);
        int n;
        n = 0;
        while (!in_ready && n < 4 * W) begin
            tick();
            n++;
        end
        chk("in_ready_before_op", in_ready, 1);
        a        = W'(av);
        b        = W'(bv);
        sub      = sv[0];
        cbin     = cv[0];
        in_valid = 1'b1;
        sb.push_back(model(av, bv, sv, cv));
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        cbin     = 1'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("in_ready_in_run", in_ready, 0);
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            tick();
            lat++;
        end
        chk("latency", lat, W);
    endtask

    task automatic take_result();
        logic [W:0] e;
        chk("out_valid_done", out_valid, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("result", result, e[W-1:0]);
            chk("cbout", cbout, e[W]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_idle", in_ready, 1);
    endtask

    task automatic run_op(input int av, input int bv, input int sv, input int cv);
        start_op(av, bv, sv, cv);
        wait_done();
        take_result();
    endtask

    initial begin
        logic [W:0] e;
        int accepts;
        int done;
        int last_cyc;
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cbin      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cbout", cbout, 0);

        // T1-T3 directed, with literal expectations
        start_op(5, 3, 1, 0);
        wait_done();
        chk("t1_result", result, 2);
        chk("t1_cbout", cbout, 0);
        take_result();
        start_op(3, 5, 1, 0);
        wait_done();
        chk("t2_result", result, 4'hE);
        chk("t2_cbout", cbout, 1);
        take_result();
        start_op(0, 0, 1, 1);
        wait_done();
        chk("t2b_result", result, 4'hF);
        chk("t2b_cbout", cbout, 1);
        take_result();
        start_op(9, 8, 0, 1);
        wait_done();
        chk("t3_result", result, 4'h2);
        chk("t3_cbout", cbout, 1);
        take_result();

        // T3 exhaustive sweep, add results also checked against the ripple adder
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < (1 << W); x++) begin
                    for (int y = 0; y < (1 << W); y++) begin
                        start_op(x, y, s, c);
                        wait_done();
                        if (s == 0) begin
                            e = ripple(W'(x), W'(y), c[0]);
                            chk("ripple", {cbout, result}, e);
                        end
                        take_result();
                    end
                end
            end
        end

        // T4 backpressure in DONE with ignored in_valid pulses
        start_op(4, 6, 0, 1);
        wait_done();
        for (int k = 0; k < 3; k++) begin
            chk("t4_out_valid_hold", out_valid, 1);
            chk("t4_result_hold", result, sb[0][W-1:0]);
            chk("t4_cbout_hold", cbout, sb[0][W]);
            a        = 4'hF;
            b        = 4'h1;
            sub      = 1'b1;
            in_valid = 1'b1;
            chk("t4_in_ready_low", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        take_result();
        run_op(12, 3, 1, 1);

        // T5 reset mid-run at cnt==2
        start_op(9, 9, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("t5_out_valid", out_valid, 0);
        chk("t5_result", result, 0);
        chk("t5_cbout", cbout, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_busy", busy, 0);
        tick();
        chk("t5_out_valid_stays", out_valid, 0);
        start_op(7, 7, 1, 0);
        wait_done();
        chk("t5_result_after", result, 0);
        chk("t5_cbout_after", cbout, 0);
        take_result();

        // T6 back-to-back with in_valid and out_ready held high
        accepts   = 0;
        done      = 0;
        last_cyc  = -1;
        cyc       = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (cyc < 100 && done < 5) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("t6_scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("t6_result", result, e[W-1:0]);
                    chk("t6_cbout", cbout, e[W]);
                end
                done++;
            end
            if (accepts >= 5) begin
                in_valid = 1'b0;
            end else if (in_ready) begin
                a    = W'($urandom);
                b    = W'($urandom);
                sub  = 1'($urandom);
                cbin = 1'($urandom);
                sb.push_back(model(int'(a), int'(b), int'(sub), int'(cbin)));
                if (last_cyc >= 0) begin
                    chk("t6_spacing", cyc - last_cyc, W + 2);
                end
                last_cyc = cyc;
                accepts++;
            end else begin
                a    = W'($urandom);
                b    = W'($urandom);
                sub  = 1'($urandom);
                cbin = 1'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_done_count", done, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
